// File: rtl/mix_columns_iter_if.sv
// -----------------------------------------------------------------------------
// mix_columns_iter_if
//   Handshake bundle for the iterative MixColumns / InvMixColumns engine.
//
//   Input side  : in_valid / in_ready handshake carrying in_state (128 bits,
//                 byte (row r, col c) at [32r+8c +: 8]) and in_inverse
//                 (0 = MixColumns, 1 = InvMixColumns).
//   Output side : out_valid / out_ready handshake carrying out_state (same
//                 byte mapping) and out_inverse (mode used for the result).
//
//   master : the environment (upstream producer + downstream consumer)
//   slave  : the engine itself
// -----------------------------------------------------------------------------
interface mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_inverse;

    modport master (
        output in_valid,
        output in_state,
        output in_inverse,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state,
        input  out_inverse
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  in_inverse,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state,
        output out_inverse
    );
endinterface

// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
//   Handshaked MixColumns / InvMixColumns engine for the AES round datapath.
//   One 128-bit state is captured per transaction and COLS_PER_CYCLE columns
//   are transformed per clock; the finished result is held on the output
//   until the downstream stage accepts it.
//
//   Parameters
//     COLS_PER_CYCLE : columns transformed per compute cycle (1, 2 or 4)
//     INVERSE_EN     : 0 removes the inverse matrix; in_inverse is ignored
//
//   Ports
//     clk   : clock, all state changes on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : slave side of mix_columns_iter_if
//             in_valid/in_ready/in_state/in_inverse   - input handshake
//             out_valid/out_ready/out_state/out_inverse - output handshake
// -----------------------------------------------------------------------------
module mix_columns_iter #(
    parameter int unsigned COLS_PER_CYCLE = 4,
    parameter bit          INVERSE_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_iter_if.slave bus
);

    localparam int unsigned STEPS    = 4 / COLS_PER_CYCLE;
    localparam logic [1:0]  LAST_CNT = 2'(STEPS - 1);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e       state_q,     state_d;
    logic [1:0]   col_cnt_q,   col_cnt_d;
    logic [127:0] cap_state_q, cap_state_d;
    logic         cap_inv_q,   cap_inv_d;
    logic [127:0] res_q,       res_d;
    logic         out_valid_q, out_valid_d;
    logic         out_inv_q,   out_inv_d;

    logic         in_ready;
    logic         accept;

    // -------------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial 0x11B
    // -------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Column packed as {b3, b2, b1, b0}, b_k = row k.
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0]  b [4];
        logic [31:0] r;
        for (int unsigned k = 0; k < 4; k++) begin
            b[k] = col[8*k +: 8];
        end
        r = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            // 2*b_k ^ 3*b_(k+1) ^ b_(k+2) ^ b_(k+3), with 3*x = xtime(x) ^ x
            r[8*k +: 8] = xtime(b[k])
                        ^ xtime(b[(k + 1) % 4]) ^ b[(k + 1) % 4]
                        ^ b[(k + 2) % 4]
                        ^ b[(k + 3) % 4];
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0]  x1 [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] r;
        for (int unsigned k = 0; k < 4; k++) begin
            x1[k] = col[8*k +: 8];
            x2[k] = xtime(x1[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
        end
        r = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
            r[8*k +: 8] = (x8[k]           ^ x4[k]           ^ x2[k])
                        ^ (x8[(k + 1) % 4] ^ x2[(k + 1) % 4] ^ x1[(k + 1) % 4])
                        ^ (x8[(k + 2) % 4] ^ x4[(k + 2) % 4] ^ x1[(k + 2) % 4])
                        ^ (x8[(k + 3) % 4] ^ x1[(k + 3) % 4]);
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Column lanes: lane j handles column col_cnt*C + j of the captured state
    // -------------------------------------------------------------------------
    logic [1:0]  lane_col [COLS_PER_CYCLE];
    logic [31:0] lane_in  [COLS_PER_CYCLE];
    logic [31:0] lane_out [COLS_PER_CYCLE];

    always_comb begin : lane_select
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
            lane_col[j] = 2'(32'(col_cnt_q) * COLS_PER_CYCLE + j);
            lane_in[j]  = '0;
            for (int unsigned r = 0; r < 4; r++) begin
                lane_in[j][8*r +: 8] = cap_state_q[32*r + 8*lane_col[j] +: 8];
            end
        end
    end

    generate
        for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
            if (INVERSE_EN) begin : g_both
                assign lane_out[j] = cap_inv_q ? mix_inv(lane_in[j]) : mix_fwd(lane_in[j]);
            end else begin : g_fwd_only
                assign lane_out[j] = mix_fwd(lane_in[j]);
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Handshake and next-state logic
    // -------------------------------------------------------------------------
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin : next_state
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        cap_state_d = cap_state_q;
        cap_inv_d   = cap_inv_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        out_inv_d   = out_inv_q;

        // Capture is shared by IDLE and the DONE handshake cycle; in_ready
        // already encodes which states may accept.
        if (accept) begin
            cap_state_d = bus.in_state;
            cap_inv_d   = bus.in_inverse & INVERSE_EN;
            col_cnt_d   = '0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
                    for (int unsigned r = 0; r < 4; r++) begin
                        res_d[32*r + 8*lane_col[j] +: 8] = lane_out[j][8*r +: 8];
                    end
                end
                if (col_cnt_q == LAST_CNT) begin
                    col_cnt_d   = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_inv_d   = cap_inv_q;
                end else begin
                    col_cnt_d = col_cnt_q + 2'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = accept ? CALC : IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_cnt_q   <= '0;
            cap_state_q <= '0;
            cap_inv_q   <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_inv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            cap_state_q <= cap_state_d;
            cap_inv_q   <= cap_inv_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            out_inv_q   <= out_inv_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_state   = res_q;
    assign bus.out_inverse = out_inv_q;

endmodule

// File: doc/mix_columns_iter.md
# mix_columns_iter

Parametrised, handshaked MixColumns / InvMixColumns engine for the AES round datapath. It sits between ShiftRows and AddRoundKey, or between InvShiftRows and InvAddRoundKey in the decrypt path. It captures one 128-bit state per transaction and processes COLS_PER_CYCLE columns per clock. The result is held until the downstream stage accepts it. It replaces the free-running single-cycle column mixer with a configurable area/throughput trade-off, a decrypt mode and flow control.

## Interface
- COLS_PER_CYCLE, 4: columns transformed per compute cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- INVERSE_EN, 1: when 0, the inverse-matrix logic is not built, in_inverse is ignored and the forward matrix is always used.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_state and in_inverse are valid.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  128  state; byte (row r, col c) = in_state[32r+8c+7 : 32r+8c].
- in_inverse  input  1  0 = MixColumns, 1 = InvMixColumns.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  result, same byte mapping as in_state.
- out_inverse  output  1  mode used for the result on out_state.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid:
  - capture in_state and in_inverse into internal registers;
  - clear column counter col_cnt;
  - go to CALC.
- CALC: in_ready=0, out_valid=0.
  - Each cycle, columns col_cnt*C .. col_cnt*C+C-1 are transformed from the captured state (C = COLS_PER_CYCLE) and written into the result register.
  - col_cnt increments by 1.
  - After the 4/C-th CALC cycle, go to DONE. col_cnt wraps to 0.
- DONE: out_valid=1; out_state and out_inverse are stable until the handshake.
  - out_valid & out_ready & in_valid: the next state is captured in the same cycle, then CALC.
  - out_valid & out_ready & !in_valid: go to IDLE.
  - !out_ready: stay in DONE. in_ready=0 and in_valid is ignored.
- in_ready = (state==IDLE) | (state==DONE & out_ready), a combinational function of state and out_ready.
- Forward column (b0..b3 = rows 0..3 of one column): out_k = 2·b_k ^ 3·b_(k+1) ^ b_(k+2) ^ b_(k+3), indices mod 4.
- Inverse column: out_k = 0e·b_k ^ 0b·b_(k+1) ^ 0d·b_(k+2) ^ 09·b_(k+3).
- All multiplies are in GF(2^8) with polynomial 0x11B, built from xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 8'h00). No lookup tables.
- in_state and in_inverse may change freely after acceptance. Only the captured copies are used.
- The result register only updates in CALC, so out_state never shows partial results while out_valid=1.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, col_cnt=0;
  - in_ready=1, out_valid=0;
  - out_state=128'h0, out_inverse=0;
  - capture registers=0.
- Reset asserted mid-CALC or in DONE aborts the transaction immediately. No output is produced for it.
- Latency: out_valid rises on the edge 4/C cycles after the accepting edge. That is 1 cycle for C=4, 2 for C=2, 4 for C=1.
- Throughput with out_ready held high and in_valid held high: one result every 4/C+1 cycles. The DONE cycle overlaps the next acceptance.
- Back-pressure: out_state, out_inverse and out_valid stay constant for any number of cycles with out_ready=0.
- An in_valid that arrives while in_ready=0 is not captured. The upstream stage must hold it until in_ready=1.

## Test plan
- Forward, C=4:
  - in_state = 128'h45454545_53535353_13131313_dbdbdbdb, in_inverse=0 -> one cycle after acceptance, out_valid=1 with out_state = 128'hbcbcbcbc_a1a1a1a1_4d4d4d4d_8e8e8e8e.
  - Columns (f2,0a,22,5c) -> (9f,dc,58,9d).
  - Columns (d4,d4,d4,d5) -> (d5,d5,d7,d6).
  - Columns (01,01,01,01) -> unchanged.
- Inverse round trip, C=1 and C=2: feed each forward result above with in_inverse=1 -> the original state is returned.
  - Latency is 4 cycles for C=1 and 2 cycles for C=2.
  - out_inverse=1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_state is stable, in_ready=0, a pulsed in_valid is not captured. On release, the held result is consumed exactly once.
- Streaming, C=4: 8 back-to-back states with out_ready=1 -> one result every 2 cycles, in order, each bit-exact against a software model of all four columns.
- Reset mid-operation: assert rst_n=0 in the second CALC cycle (C=1) -> out_valid=0 and out_state=0 immediately. After release, in_ready=1 and a new state completes normally.
- INVERSE_EN=0: in_inverse=1 with the forward vector above -> the forward result 8e4da1bc per column, out_inverse=0.
